// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//
// Time-multiplexed scanner for a 4-digit common-anode seven-segment display.
// Each digit slot lasts REFRESH_DIV cycles: one all-off guard cycle followed by
// REFRESH_DIV-1 lit cycles. A newly loaded value waits in a shadow register
// and is moved to the displayed value only at a frame boundary, so a number
// on the display never tears.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   value     : value to display, value[3:0] is digit 0 (rightmost)
//   load      : single-cycle strobe, captures value into the shadow register
//   enable    : scan enable; low darkens the display and freezes the scan
//   blank_lz  : leading-zero blanking enable
//   dp_mask   : per-digit decimal point request, active-high
//   hex       : nibble of the current digit, feeds the segment decoder
//   an        : anodes, active-low, an[k] selects digit k
//   dp        : decimal point, active-low
//   pending   : shadow holds a value not yet displayed
//   frame     : one-cycle pulse during the digit 0 guard cycle of each frame
// -----------------------------------------------------------------------------
module seg_display_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  hex,
  output logic [3:0]  an,
  output logic        dp,
  output logic        pending,
  output logic        frame
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Registers
  logic [CNT_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow;
  logic [15:0]      r_disp;
  logic             r_pending;
  logic [3:0]       r_hex;
  logic [3:0]       r_an;
  logic             r_dp;
  logic             r_frame;
  logic             r_boot;
  state_t           r_state;

  // Next-state values
  logic [CNT_W-1:0] w_div_next;
  logic [1:0]       w_idx_next;
  logic [15:0]      w_shadow_next;
  logic [15:0]      w_disp_next;
  logic             w_pending_next;
  logic [3:0]       w_hex_next;
  logic [3:0]       w_an_next;
  logic             w_dp_next;
  logic             w_frame_next;
  logic             w_boot_next;
  state_t           w_state_next;

  logic             w_tick;
  logic [3:0]       w_blank;
  logic [3:0]       w_nibble;

  assign w_tick   = enable && (r_div_cnt == CNT_LAST);
  assign w_nibble = r_disp[{r_idx, 2'b00} +: 4];

  // Digit k (k >= 1) is a leading zero when every nibble from k upward is 0.
  // Digit 0 always shows, so a displayed zero is never fully dark.
  assign w_blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign w_blank[gi] = blank_lz && (r_disp[15:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    w_div_next     = r_div_cnt;
    w_idx_next     = r_idx;
    w_shadow_next  = r_shadow;
    w_disp_next    = r_disp;
    w_pending_next = r_pending;
    w_hex_next     = r_hex;
    w_an_next      = r_an;
    w_dp_next      = r_dp;
    w_frame_next   = 1'b0;
    w_boot_next    = r_boot;
    w_state_next   = r_state;

    if (!enable) begin
      // Frozen: counter and index hold; returning to GUARD makes the scan
      // resume with a guard cycle on the same digit.
      w_an_next    = 4'b1111;
      w_state_next = ST_GUARD;
    end else if (r_boot) begin
      // First enabled edge after reset opens the initial frame so the
      // reset guard cycle carries a frame pulse like every later frame.
      w_boot_next  = 1'b0;
      w_frame_next = 1'b1;
    end else if (w_tick) begin
      w_div_next   = '0;
      w_idx_next   = r_idx + 2'd1;
      w_an_next    = 4'b1111;
      w_state_next = ST_GUARD;
      if (r_idx == 2'd3) begin
        w_frame_next = 1'b1;
        if (r_pending) begin
          w_disp_next    = r_shadow;
          w_pending_next = 1'b0;
        end
      end
    end else begin
      w_div_next = r_div_cnt + CNT_W'(1);
      if (r_state == ST_GUARD) begin
        w_hex_next   = w_nibble;
        w_dp_next    = ~dp_mask[r_idx];
        w_an_next    = w_blank[r_idx] ? 4'b1111 : ~(4'b0001 << r_idx);
        w_state_next = ST_SHOW;
      end
    end

    // A load always wins over the boundary clear: at a boundary the display
    // takes the old shadow while the new value stays pending.
    if (load) begin
      w_shadow_next  = value;
      w_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= 2'd0;
      r_shadow  <= 16'h0000;
      r_disp    <= 16'h0000;
      r_pending <= 1'b0;
      r_hex     <= 4'h0;
      r_an      <= 4'b1111;
      r_dp      <= 1'b1;
      r_frame   <= 1'b0;
      r_boot    <= 1'b1;
      r_state   <= ST_GUARD;
    end else begin
      r_div_cnt <= w_div_next;
      r_idx     <= w_idx_next;
      r_shadow  <= w_shadow_next;
      r_disp    <= w_disp_next;
      r_pending <= w_pending_next;
      r_hex     <= w_hex_next;
      r_an      <= w_an_next;
      r_dp      <= w_dp_next;
      r_frame   <= w_frame_next;
      r_boot    <= w_boot_next;
      r_state   <= w_state_next;
    end
  end

  assign hex     = r_hex;
  assign an      = r_an;
  assign dp      = r_dp;
  assign pending = r_pending;
  assign frame   = r_frame;

endmodule

// File: tb/tb_seg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scanner
//
// Directed bench for seg_display_scanner with REFRESH_DIV=4. The stimulus
// process pushes the expected lit state of each digit slot into a queue; a
// separate monitor anchors on the frame pulse and compares every slot of a
// frame against the queue. Reset, pending and enable behaviour are checked
// directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_seg_display_scanner;

  localparam int DIV = 4;

  typedef struct {
    logic [3:0] hex;
    logic [3:0] an;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        enable;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        dp;
  logic        pending;
  logic        frame;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  seg_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .enable   (enable),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .hex      (hex),
    .an       (an),
    .dp       (dp),
    .pending  (pending),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] h, input logic [3:0] a, input logic d);
    exp_t e;
    e.hex = h;
    e.an  = a;
    e.dp  = d;
    exp_q.push_back(e);
  endtask

  // Advance one cycle; sample 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (frame !== 1'b1 && n < 64);
    check("frame_wait", {15'd0, frame}, 16'd1);
  endtask

  task automatic wait_q_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    check("queue_drain", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  // Monitor: a frame pulse with a full frame of expectations queued starts a
  // check of all four slots (guard at +4k, lit at +4k+1, still lit at +4k+3).
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame === 1'b1 && exp_q.size() >= 4) begin
        for (int k = 0; k < 4; k++) begin
          check("guard_an", {12'd0, an}, 16'hF);
          @(negedge clk);
          e = exp_q.pop_front();
          check("slot_hex", {12'd0, hex}, {12'd0, e.hex});
          check("slot_an",  {12'd0, an},  {12'd0, e.an});
          check("slot_dp",  {15'd0, dp},  {15'd0, e.dp});
          $display("slot %0d: hex=%h an=%b dp=%b", k, hex, an, dp);
          @(negedge clk);
          @(negedge clk);
          check("hold_an", {12'd0, an}, {12'd0, e.an});
          if (k < 3) @(negedge clk);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n    = 1'b0;
    value    = 16'h0000;
    load     = 1'b0;
    enable   = 1'b1;
    blank_lz = 1'b0;
    dp_mask  = 4'b0100;

    // Reset state
    step(2);
    check("rst_hex", {12'd0, hex}, 16'h0);
    check("rst_an",  {12'd0, an},  16'hF);
    check("rst_dp",  {15'd0, dp},  16'd1);
    check("rst_pending", {15'd0, pending}, 16'd0);
    check("rst_frame",   {15'd0, frame},   16'd0);
    rst_n = 1'b1;
    $display("reset released");

    // Scenario 1: reset mid-scan while digit 2 of 1A2F is lit
    wait_frame();
    do_load(16'h1A2F);
    wait_frame();
    step(9);
    check("s1_pre_an",  {12'd0, an},  16'hB);
    check("s1_pre_hex", {12'd0, hex}, 16'hA);
    do_load(16'hFFFF);
    check("s1_pre_pending", {15'd0, pending}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("s1_async_an",  {12'd0, an},  16'hF);
    check("s1_async_hex", {12'd0, hex}, 16'h0);
    check("s1_async_dp",  {15'd0, dp},  16'd1);
    check("s1_async_pending", {15'd0, pending}, 16'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("s1_frame", {15'd0, frame}, 16'd1);
    check("s1_guard_an", {12'd0, an}, 16'hF);
    step(1);
    check("s1_frame_low", {15'd0, frame}, 16'd0);
    check("s1_d0_an",  {12'd0, an},  16'hE);
    check("s1_d0_hex", {12'd0, hex}, 16'h0);
    $display("scenario 1 done");

    // Scenario 2: load 1A2F with dp on digit 2
    wait_frame();
    do_load(16'h1A2F);
    check("s2_pending", {15'd0, pending}, 16'd1);
    push_exp(4'hF, 4'b1110, 1'b1); push_exp(4'h2, 4'b1101, 1'b1);
    push_exp(4'hA, 4'b1011, 1'b0); push_exp(4'h1, 4'b0111, 1'b1);
    wait_q_empty();
    $display("scenario 2 done");

    // Scenario 3: load 5555 mid-frame while 1A2F is shown
    push_exp(4'hF, 4'b1110, 1'b1); push_exp(4'h2, 4'b1101, 1'b1);
    push_exp(4'hA, 4'b1011, 1'b0); push_exp(4'h1, 4'b0111, 1'b1);
    push_exp(4'h5, 4'b1110, 1'b1); push_exp(4'h5, 4'b1101, 1'b1);
    push_exp(4'h5, 4'b1011, 1'b0); push_exp(4'h5, 4'b0111, 1'b1);
    wait_frame();
    step(5);
    do_load(16'h5555);
    check("s3_pending_rise", {15'd0, pending}, 16'd1);
    step(9);
    check("s3_pending_hold", {15'd0, pending}, 16'd1);
    step(1);
    check("s3_pending_fall", {15'd0, pending}, 16'd0);
    check("s3_frame", {15'd0, frame}, 16'd1);
    wait_q_empty();
    $display("scenario 3 done");

    // Scenario 4: leading-zero blanking of 0030
    wait_frame();
    blank_lz = 1'b1;
    dp_mask  = 4'b0000;
    do_load(16'h0030);
    push_exp(4'h0, 4'b1110, 1'b1); push_exp(4'h3, 4'b1101, 1'b1);
    push_exp(4'h0, 4'b1111, 1'b1); push_exp(4'h0, 4'b1111, 1'b1);
    wait_q_empty();
    $display("scenario 4 done");

    // Scenario 5: load BEEF on the boundary tick while 1234 is pending
    wait_frame();
    blank_lz = 1'b0;
    dp_mask  = 4'b0001;
    do_load(16'h1234);
    step(14);
    check("s5_pending_before", {15'd0, pending}, 16'd1);
    do_load(16'hBEEF);
    check("s5_pending_kept", {15'd0, pending}, 16'd1);
    check("s5_frame", {15'd0, frame}, 16'd1);
    push_exp(4'h4, 4'b1110, 1'b0); push_exp(4'h3, 4'b1101, 1'b1);
    push_exp(4'h2, 4'b1011, 1'b1); push_exp(4'h1, 4'b0111, 1'b1);
    push_exp(4'hF, 4'b1110, 1'b0); push_exp(4'hE, 4'b1101, 1'b1);
    push_exp(4'hE, 4'b1011, 1'b1); push_exp(4'hB, 4'b0111, 1'b1);
    step(16);
    check("s5_pending_clear", {15'd0, pending}, 16'd0);
    wait_q_empty();
    $display("scenario 4/5 done");

    // Scenario 6: drop enable while digit 2 is lit
    wait_frame();
    step(9);
    check("s6_pre_an",  {12'd0, an},  16'hB);
    check("s6_pre_hex", {12'd0, hex}, 16'hE);
    enable = 1'b0;
    step(1);
    check("s6_dark_an", {12'd0, an}, 16'hF);
    do_load(16'h0042);
    check("s6_load_while_off", {15'd0, pending}, 16'd1);
    step(3);
    check("s6_still_dark", {12'd0, an}, 16'hF);
    check("s6_no_frame", {15'd0, frame}, 16'd0);
    enable = 1'b1;
    check("s6_guard_an", {12'd0, an}, 16'hF);
    step(1);
    check("s6_resume_an",  {12'd0, an},  16'hB);
    check("s6_resume_hex", {12'd0, hex}, 16'hE);
    check("s6_resume_dp",  {15'd0, dp},  16'd1);
    step(1);
    check("s6_resume_hold", {12'd0, an}, 16'hB);
    step(1);
    check("s6_next_guard", {12'd0, an}, 16'hF);
    step(1);
    check("s6_d3_an",  {12'd0, an},  16'h7);
    check("s6_d3_hex", {12'd0, hex}, 16'hB);
    step(3);
    check("s6_frame", {15'd0, frame}, 16'd1);
    check("s6_pending_clear", {15'd0, pending}, 16'd0);
    push_exp(4'h2, 4'b1110, 1'b0); push_exp(4'h4, 4'b1101, 1'b1);
    push_exp(4'h0, 4'b1011, 1'b1); push_exp(4'h0, 4'b0111, 1'b1);
    wait_q_empty();
    $display("scenario 6 done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
